// File: rtl/cpu_pkg.sv
// Shared constants and fetch-FSM state encoding for the CPU front end.
// Default widths and the halt encoding live here so the core and its parent agree on them.
package cpu_pkg;

    localparam int unsigned N_DEFAULT = 16;
    localparam int unsigned R_DEFAULT = 6;
    localparam logic [15:0] HALT_OP_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: single-cycle fetch from a combinational instruction memory,
// with decode backpressure, redirect flush and a sticky halt on HALT_OP.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned N       = N_DEFAULT,
    parameter int unsigned R       = R_DEFAULT,
    parameter logic [N-1:0] HALT_OP = N'(HALT_OP_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [R-1:0] imem_addr,
    input  logic [N-1:0] imem_rdata,
    input  logic         redirect_valid,
    input  logic [R-1:0] redirect_pc,
    output logic         instr_valid,
    output logic [N-1:0] instr,
    output logic [R-1:0] instr_pc,
    input  logic         instr_ready,
    output logic         halted
);

    fetch_state_e state_q;
    logic [R-1:0] pc_q;
    logic         accept;
    logic         load;
    logic         is_halt;

    assign imem_addr = pc_q;
    assign accept    = instr_valid && instr_ready;
    // A fetch happens only when the output slot is free or is being drained this cycle.
    assign load      = (state_q == FETCH) && (!instr_valid || instr_ready) && !redirect_valid;
    assign is_halt   = (imem_rdata == HALT_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over everything, including a stalled or halted instruction.
            state_q     <= FETCH;
            pc_q        <= redirect_pc;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (load) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc_q;
                        instr_valid <= 1'b1;
                        if (is_halt) begin
                            state_q <= HALT;
                            halted  <= 1'b1;
                        end else begin
                            pc_q <= pc_q + R'(1);
                        end
                    end else if (accept) begin
                        instr_valid <= 1'b0;
                    end
                end
                HALT: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random backpressure/redirect traffic,
// checked by a scoreboard holding the instruction stream the program order implies.
module tb_ifetch_unit;

    localparam int N = 16;
    localparam int R = 6;
    localparam logic [15:0] HALT = 16'hFFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [R-1:0] imem_addr;
    logic [N-1:0] imem_rdata;
    logic         redirect_valid;
    logic [R-1:0] redirect_pc;
    logic         instr_valid;
    logic [N-1:0] instr;
    logic [R-1:0] instr_pc;
    logic         instr_ready;
    logic         halted;

    logic [N-1:0] mem [64];

    typedef struct packed {
        logic [R-1:0] pc;
        logic [N-1:0] data;
    } item_t;

    item_t exp_q[$];
    item_t mon_e;
    int    checks = 0;
    int    passed = 0;

    ifetch_unit #(.N(N), .R(R), .HALT_OP(HALT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .halted         (halted)
    );

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endfunction

    // Program order from a start address: sequential, wrapping, ending at the first halt.
    task automatic expect_stream(input logic [R-1:0] start);
        logic [R-1:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({a, mem[a]});
            if (mem[a] == HALT) break;
            a = a + R'(1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [R-1:0] pc,
                             input logic [N-1:0] d);
        check({name, "_valid"}, 32'(instr_valid), 32'(v));
        if (v) begin
            check({name, "_pc"}, 32'(instr_pc), 32'(pc));
            check({name, "_data"}, 32'(instr), 32'(d));
        end
    endtask

    // Monitor: every accepted instruction must be the next one in program order.
    always @(negedge clk) begin
        if (rst_n && !redirect_valid && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_accept: got pc %0d data %0h, required no instruction",
                         instr_pc, instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("accept_pc", 32'(instr_pc), 32'(mon_e.pc));
                check("accept_data", 32'(instr), 32'(mon_e.data));
                check("accept_halted", 32'(halted), 32'(mon_e.data == HALT));
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom_range(16'hFFFE));
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = HALT;
        expect_stream(0);

        #12;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);

        // Startup latency and streaming.
        @(negedge clk) rst_n = 1'b1;
        step();
        check("boot_edge1_valid", 32'(instr_valid), 32'd0);
        step();
        check_out("edge2", 1'b1, 6'd0, 16'h1111);
        step();
        check_out("edge3", 1'b1, 6'd1, 16'h2222);

        // Backpressure for three cycles.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 1'b1, 6'd1, 16'h2222);
            check("stall_addr", 32'(imem_addr), 32'd2);
        end
        instr_ready = 1'b1;
        step();
        check_out("resume", 1'b1, 6'd2, 16'h3333);

        // Redirect while stalled.
        instr_ready = 1'b0;
        step();
        check_out("stall2", 1'b1, 6'd2, 16'h3333);
        redirect_valid = 1'b1;
        redirect_pc    = 6'd5;
        expect_stream(6'd5);
        step();
        check("redir_flush_valid", 32'(instr_valid), 32'd0);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        step();
        check_out("redir5", 1'b1, 6'd5, mem[5]);

        // Run into the halt at address 3.
        redirect_valid = 1'b1;
        redirect_pc    = 6'd0;
        expect_stream(6'd0);
        step();
        check("redir0_flush", 32'(instr_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        step();
        step();
        step();
        check_out("halt", 1'b1, 6'd3, HALT);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_addr", 32'(imem_addr), 32'd3);
        instr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_out("halt_hold", 1'b1, 6'd3, HALT);
            check("halt_hold_addr", 32'(imem_addr), 32'd3);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_after_valid", 32'(instr_valid), 32'd0);
            check("halt_after_flag", 32'(halted), 32'd1);
            check("halt_after_addr", 32'(imem_addr), 32'd3);
        end

        // Redirect out of halt and across the wrap point.
        redirect_valid = 1'b1;
        redirect_pc    = 6'd62;
        expect_stream(6'd62);
        step();
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_valid", 32'(instr_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        check_out("wrap62", 1'b1, 6'd62, mem[62]);
        step();
        check_out("wrap63", 1'b1, 6'd63, mem[63]);
        step();
        check_out("wrap0", 1'b1, 6'd0, mem[0]);
        step();
        check_out("wrap1", 1'b1, 6'd1, mem[1]);

        // Asynchronous reset in the middle of a stall.
        instr_ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        expect_stream(6'd0);
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", 32'(instr), 32'd0);
        check("arst_pc", 32'(instr_pc), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_addr", 32'(imem_addr), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        instr_ready = 1'b1;
        step();
        check("arst_edge1_valid", 32'(instr_valid), 32'd0);
        step();
        check_out("arst_edge2", 1'b1, 6'd0, 16'h1111);

        // Random traffic over a fresh random program.
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(7) == 0) ? HALT : 16'($urandom_range(16'hFFFE));
        mem[$urandom_range(63)] = HALT;
        expect_stream(6'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 800; i++) begin
            step();
            instr_ready = ($urandom_range(3) != 0);
            if ($urandom_range(11) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 6'($urandom_range(63));
                expect_stream(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter N, default 16: instruction/data width in bits.
REQ-002 SHALL have parameter R, default 6: instruction-memory word-address width (64 slots).
REQ-003 SHALL have parameter HALT_OP, default 16'hFFFF: instruction encoding that halts fetch.
REQ-004 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: imem_addr  output  R  word address to instruction memory.
REQ-007 SHALL have ports: imem_rdata  input  N  combinational read data from instruction memory at imem_addr.
REQ-008 SHALL have ports: redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have ports: redirect_pc  input  R  redirect target word address.
REQ-010 SHALL have ports: instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
REQ-011 SHALL have ports: instr  output  N  fetched instruction register.
REQ-012 SHALL have ports: instr_pc  output  R  address the instruction was fetched from.
REQ-013 SHALL have ports: instr_ready  input  1  downstream decode accepts instr this cycle.
REQ-014 SHALL have ports: halted  output  1  fetch stopped on HALT_OP.

Function
REQ-015 SHALL drive imem_addr combinationally from internal pc register; no other path.
REQ-016 SHALL implement FSM states BOOT, FETCH, HALT; BOOT -> FETCH unconditionally after one cycle, no fetch in BOOT.
REQ-017 SHALL define accept = instr_valid && instr_ready; load = FETCH && (!instr_valid || instr_ready) && !redirect_valid.
REQ-018 SHALL on load: instr <= imem_rdata, instr_pc <= pc, instr_valid <= 1, pc <= pc+1 (one-cycle fetch latency, one instruction per cycle throughput).
REQ-019 SHALL wrap pc modulo 2**R (63 -> 0 at R=6), no error flag.
REQ-020 SHALL on accept without load: instr_valid <= 0.
REQ-021 SHALL on instr_valid && !instr_ready: hold instr, instr_pc, pc unchanged (backpressure, no instruction lost or duplicated).
REQ-022 SHALL give redirect_valid highest priority in any state: pc <= redirect_pc, instr_valid <= 0 (flush, even if stalled), state <= FETCH, halted <= 0; first redirected instruction valid two edges after redirect edge.
REQ-023 SHALL on load with imem_rdata == HALT_OP: capture and present it normally, state <= HALT, halted <= 1, pc not incremented.
REQ-024 SHALL in HALT perform no loads; pending halt instruction remains until accepted; only redirect or reset exits HALT.
REQ-025 SHALL treat redirect and HALT_OP in same cycle as redirect only (halt instruction discarded).

Reset
REQ-026 SHALL on rst_n low asynchronously set pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, state=BOOT.
REQ-027 SHALL on reset mid-stall or mid-HALT discard held instruction; after release restart from address 0 via BOOT.

Structure
REQ-028 SHALL place FSM state enum (BOOT/FETCH/HALT) and default N, R, HALT_OP constants in shared package cpu_pkg.
REQ-029 SHALL be a single module with no sub-modules; imem instantiated alongside it by the parent.

Verification
REQ-030 SHALL bench: release reset, instr_ready=1, imem holding 0x1111,0x2222,0x3333 at 0..2 -> instr_valid first at edge 2, instr_pc 0,1,2 on consecutive cycles with matching data.
REQ-031 SHALL bench: deassert instr_ready 3 cycles while instr=0x2222 -> instr, instr_pc, imem_addr frozen; resumes with 0x3333 next, no duplicate or gap.
REQ-032 SHALL bench: redirect_valid=1, redirect_pc=5 while stalled -> instr_valid=0 next edge, instr_pc=5 valid edge after.
REQ-033 SHALL bench: HALT_OP at address 3 -> 0xFFFF presented with instr_pc=3, halted=1, imem_addr stays 3, no further valid after accept; redirect to 0 clears halted.
REQ-034 SHALL bench: start pc via redirect to 62 -> instr_pc sequence 62, 63, 0, 1.
REQ-035 SHALL bench: assert rst_n low between clock edges during stall -> all outputs zero immediately, refetch from address 0 after release.
